// File: rtl/int_controller.sv
// -----------------------------------------------------------------------------
// int_controller
//
// Interrupt controller that sits between the peripherals and the CPU PC.
// Up to NUM_SRC asynchronous request lines are synchronised, latched (rising
// edge or level, per source), masked and priority-encoded (lowest index wins).
// A single-cycle interrupt pulse with a 4-bit vector is issued only while the
// fetch/branch pipeline is in a safe window. Further interrupts are blocked
// until the handler returns (no nesting).
//
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   irq_src        asynchronous request lines, one per source
//   reg_wr/reg_rd  register write / read strobes
//   reg_addr       0=ENABLE 1=PENDING(W1C) 2=IN_SERVICE 3=CTRL(bit0 GIE)
//   reg_wdata      write data
//   reg_rdata      read data, registered: valid the cycle after reg_rd
//   hazard, branch_hazard, p_cache_miss, pc_redirect
//                  pipeline conditions; any of them holds off the pulse
//   ret_int        return-from-interrupt executed
//   interrupt      one-cycle request to the PC
//   int_addr       vector index of the armed / firing source
//   int_pending    an enabled request is pending and GIE is set
// -----------------------------------------------------------------------------
module int_controller #(
  parameter int          NUM_SRC     = 16,
  parameter logic [15:0] EDGE_MASK   = 16'hFFFF,
  parameter int          SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               reg_wr,
  input  logic               reg_rd,
  input  logic [1:0]         reg_addr,
  input  logic [15:0]        reg_wdata,
  output logic [15:0]        reg_rdata,
  input  logic               hazard,
  input  logic               branch_hazard,
  input  logic               p_cache_miss,
  input  logic               pc_redirect,
  input  logic               ret_int,
  output logic               interrupt,
  output logic [3:0]         int_addr,
  output logic               int_pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    FIRE    = 2'd2,
    SERVICE = 2'd3
  } state_e;

  localparam logic [NUM_SRC-1:0] EDGE = EDGE_MASK[NUM_SRC-1:0];

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_INSERV  = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;

  // Registered state
  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q, sync_d;
  logic [NUM_SRC-1:0] prev_q, prev_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] in_service_q, in_service_d;
  logic               gie_q, gie_d;
  logic [3:0]         addr_q, addr_d;
  logic [15:0]        rdata_q, rdata_d;
  state_e             state_q, state_d;

  // Combinational helpers
  logic [NUM_SRC-1:0] sync_out;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] fire_clr;
  logic [NUM_SRC-1:0] addr_onehot;
  logic [NUM_SRC-1:0] cand_vec;
  logic               cand_valid;
  logic [3:0]         cand_idx;
  logic               safe;
  logic               fire;
  logic               ret;

  // Zero-extend a per-source vector onto the 16-bit register bus.
  function automatic logic [15:0] ext(input logic [NUM_SRC-1:0] v);
    logic [15:0] r;
    r              = '0;
    r[NUM_SRC-1:0] = v;
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Request path: synchroniser, edge detect, PENDING update
  // ---------------------------------------------------------------------------
  always_comb begin
    sync_d[0] = irq_src;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    sync_out = sync_q[SYNC_STAGES-1];
    prev_d   = sync_out;
    rise     = sync_out & ~prev_q & EDGE;

    w1c = '0;
    if (reg_wr && reg_addr == ADDR_PENDING) begin
      w1c = reg_wdata[NUM_SRC-1:0] & EDGE;
    end

    // Edge bits are sticky with clears applied before the new edge, so a
    // same-cycle set always wins. Level bits simply mirror the synced line.
    pending_d = ((((pending_q & ~w1c & ~fire_clr) | rise)) & EDGE)
              | (sync_out & ~EDGE);
  end

  // ---------------------------------------------------------------------------
  // Candidate selection: lowest enabled pending index
  // ---------------------------------------------------------------------------
  always_comb begin
    cand_vec   = pending_q & enable_q;
    cand_valid = gie_q & (|cand_vec);
    cand_idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand_vec[i]) cand_idx = 4'(i);
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      addr_onehot[i] = (addr_q == 4'(i));
    end
    safe = ~hazard & ~branch_hazard & ~p_cache_miss & ~pc_redirect;
  end

  // ---------------------------------------------------------------------------
  // FSM next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (cand_valid) begin
          state_d = ARM;
          addr_d  = cand_idx;
        end
      end
      ARM: begin
        if (!cand_valid) begin
          state_d = IDLE;
        end else if (cand_idx != addr_q) begin
          // Covers a higher-priority arrival and also the armed source being
          // cleared while a lower one is still pending; re-check next cycle.
          addr_d = cand_idx;
        end else if (safe) begin
          state_d = FIRE;
        end
      end
      FIRE: begin
        state_d = SERVICE;
      end
      SERVICE: begin
        if (ret_int) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    fire      = (state_q == FIRE);
    ret       = (state_q == SERVICE) && ret_int;
    interrupt = fire;
    fire_clr  = fire ? (addr_onehot & EDGE) : '0;
  end

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  always_comb begin
    enable_d     = enable_q;
    gie_d        = gie_q;
    in_service_d = in_service_q;
    rdata_d      = rdata_q;

    if (reg_wr && reg_addr == ADDR_ENABLE) enable_d = reg_wdata[NUM_SRC-1:0];
    if (reg_wr && reg_addr == ADDR_CTRL)   gie_d    = reg_wdata[0];

    if (fire)     in_service_d = addr_onehot;
    else if (ret) in_service_d = '0;

    if (reg_rd) begin
      unique case (reg_addr)
        ADDR_ENABLE:  rdata_d = ext(enable_q);
        ADDR_PENDING: rdata_d = ext(pending_q);
        ADDR_INSERV:  rdata_d = ext(in_service_q);
        ADDR_CTRL:    rdata_d = {15'b0, gie_q};
        default:      rdata_d = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its _d input regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= '0;
      prev_q       <= '0;
      pending_q    <= '0;
      enable_q     <= '0;
      in_service_q <= '0;
      gie_q        <= 1'b0;
      addr_q       <= '0;
      rdata_q      <= '0;
      state_q      <= IDLE;
    end else begin
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      pending_q    <= pending_d;
      enable_q     <= enable_d;
      in_service_q <= in_service_d;
      gie_q        <= gie_d;
      addr_q       <= addr_d;
      rdata_q      <= rdata_d;
      state_q      <= state_d;
    end
  end

  assign reg_rdata   = rdata_q;
  assign int_addr    = addr_q;
  assign int_pending = cand_valid;

endmodule

// File: tb/tb_int_controller.sv
// -----------------------------------------------------------------------------
// tb_int_controller
//
// Directed stimulus for int_controller. Stimulus pushes expected interrupt
// vectors and expected register read data into queues; a monitor process pops
// and compares whenever the DUT fires an interrupt or presents read data.
// -----------------------------------------------------------------------------
module tb_int_controller;

  localparam int NUM_SRC = 16;

  logic               clk;
  logic               rst;
  logic [NUM_SRC-1:0] irq_src;
  logic               reg_wr;
  logic               reg_rd;
  logic [1:0]         reg_addr;
  logic [15:0]        reg_wdata;
  logic [15:0]        reg_rdata;
  logic               hazard;
  logic               branch_hazard;
  logic               p_cache_miss;
  logic               pc_redirect;
  logic               ret_int;
  logic               interrupt;
  logic [3:0]         int_addr;
  logic               int_pending;

  int_controller dut (
    .clk          (clk),
    .rst          (rst),
    .irq_src      (irq_src),
    .reg_wr       (reg_wr),
    .reg_rd       (reg_rd),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_rdata    (reg_rdata),
    .hazard       (hazard),
    .branch_hazard(branch_hazard),
    .p_cache_miss (p_cache_miss),
    .pc_redirect  (pc_redirect),
    .ret_int      (ret_int),
    .interrupt    (interrupt),
    .int_addr     (int_addr),
    .int_pending  (int_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] vec;
  } int_exp_t;

  typedef struct {
    string       name;
    logic [15:0] val;
  } rd_exp_t;

  int_exp_t int_q[$];
  rd_exp_t  rd_q[$];
  int       checks   = 0;
  int       failures = 0;
  int       int_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin : monitor
    logic    prev_int;
    logic    rd_armed;
    int_exp_t ie;
    rd_exp_t  re;
    prev_int = 1'b0;
    rd_armed = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_int = 1'b0;
        rd_armed = 1'b0;
      end else begin
        if (interrupt) begin
          check("int_expected", 32'(int_q.size() != 0), 1);
          check("pulse_width", 32'(prev_int), 0);
          if (int_q.size() != 0) begin
            ie = int_q.pop_front();
            check(ie.name, 32'(int_addr), 32'(ie.vec));
          end
          int_seen++;
        end
        prev_int = interrupt;
        if (rd_armed) begin
          check("rd_expected", 32'(rd_q.size() != 0), 1);
          if (rd_q.size() != 0) begin
            re = rd_q.pop_front();
            check(re.name, 32'(reg_rdata), 32'(re.val));
          end
        end
        rd_armed = reg_rd;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [15:0] d);
    tick();
    reg_wr    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    tick();
    reg_wr    = 1'b0;
  endtask

  task automatic reg_read(input string name, input logic [1:0] a, input logic [15:0] exp);
    rd_exp_t e;
    e.name = name;
    e.val  = exp;
    tick();
    rd_q.push_back(e);
    reg_rd   = 1'b1;
    reg_addr = a;
    tick();
    reg_rd   = 1'b0;
  endtask

  task automatic expect_int(input string name, input logic [3:0] v);
    int_exp_t e;
    e.name = name;
    e.vec  = v;
    int_q.push_back(e);
  endtask

  task automatic pulse(input int src);
    tick();
    irq_src[src] = 1'b1;
    tick();
    tick();
    irq_src[src] = 1'b0;
  endtask

  task automatic do_ret();
    tick();
    ret_int = 1'b1;
    tick();
    ret_int = 1'b0;
  endtask

  task automatic wait_int(input string name, input int budget);
    int start;
    start = int_seen;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      if (int_seen != start) break;
    end
    check(name, 32'(int_seen - start), 1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    rst           = 1'b1;
    irq_src       = '0;
    reg_wr        = 1'b0;
    reg_rd        = 1'b0;
    reg_addr      = '0;
    reg_wdata     = '0;
    hazard        = 1'b0;
    branch_hazard = 1'b0;
    p_cache_miss  = 1'b0;
    pc_redirect   = 1'b0;
    ret_int       = 1'b0;

    repeat (3) tick();
    check("rst_interrupt", 32'(interrupt), 0);
    check("rst_int_addr", 32'(int_addr), 0);
    check("rst_int_pending", 32'(int_pending), 0);
    check("rst_rdata", 32'(reg_rdata), 0);
    rst = 1'b0;
    reg_read("rst_enable", 2'd0, 16'h0000);
    reg_read("rst_ctrl", 2'd3, 16'h0000);

    // 1: single edge source
    reg_write(2'd3, 16'h0001);
    reg_write(2'd0, 16'h0001);
    expect_int("t1_vec", 4'd0);
    pulse(0);
    wait_int("t1_timeout", 30);
    reg_read("t1_in_service", 2'd2, 16'h0001);
    reg_read("t1_pending", 2'd1, 16'h0000);
    do_ret();
    reg_read("t1_in_service_ret", 2'd2, 16'h0000);

    // 2: priority between src3 and src5
    reg_write(2'd3, 16'h0000);
    reg_write(2'd0, 16'h0028);
    tick();
    irq_src[3] = 1'b1;
    irq_src[5] = 1'b1;
    tick();
    tick();
    irq_src[3] = 1'b0;
    irq_src[5] = 1'b0;
    repeat (4) tick();
    reg_read("t2_pending", 2'd1, 16'h0028);
    check("t2_int_pending_gie0", 32'(int_pending), 0);
    expect_int("t2_vec_first", 4'd3);
    expect_int("t2_vec_second", 4'd5);
    reg_write(2'd3, 16'h0001);
    wait_int("t2_timeout_a", 30);
    reg_read("t2_in_service_a", 2'd2, 16'h0008);
    do_ret();
    wait_int("t2_timeout_b", 30);
    reg_read("t2_in_service_b", 2'd2, 16'h0020);
    do_ret();

    // 3: held off by cache miss, higher-priority update while armed
    reg_write(2'd0, 16'h0006);
    p_cache_miss = 1'b1;
    pulse(2);
    repeat (6) tick();
    check("t3_arm_addr2", 32'(int_addr), 2);
    pulse(1);
    repeat (6) tick();
    check("t3_arm_addr1", 32'(int_addr), 1);
    check("t3_int_pending", 32'(int_pending), 1);
    expect_int("t3_vec_first", 4'd1);
    expect_int("t3_vec_second", 4'd2);
    tick();
    p_cache_miss = 1'b0;
    @(negedge clk);
    check("t3_arm_hold", 32'(interrupt), 0);
    @(negedge clk);
    check("t3_fire_latency", 32'(interrupt), 1);
    do_ret();
    wait_int("t3_timeout", 30);
    do_ret();

    // 4: masking while armed returns to IDLE without firing
    reg_write(2'd0, 16'h0008);
    p_cache_miss = 1'b1;
    pulse(3);
    repeat (6) tick();
    check("t4_arm_addr", 32'(int_addr), 3);
    check("t4_int_pending", 32'(int_pending), 1);
    reg_write(2'd0, 16'h0000);
    p_cache_miss = 1'b0;
    repeat (10) tick();
    reg_read("t4_pending_kept", 2'd1, 16'h0008);
    check("t4_int_pending_masked", 32'(int_pending), 0);
    reg_write(2'd1, 16'h0008);
    reg_read("t4_pending_w1c", 2'd1, 16'h0000);

    // 5: no nesting; ret_int outside SERVICE ignored
    reg_write(2'd0, 16'h0003);
    expect_int("t5_vec_first", 4'd0);
    pulse(0);
    wait_int("t5_timeout_a", 30);
    pulse(1);
    repeat (4) tick();
    reg_read("t5_pending_in_service", 2'd1, 16'h0002);
    check("t5_int_pending", 32'(int_pending), 1);
    expect_int("t5_vec_second", 4'd1);
    do_ret();
    wait_int("t5_timeout_b", 30);
    do_ret();
    do_ret();
    repeat (4) tick();
    reg_read("t5_in_service_idle", 2'd2, 16'h0000);
    reg_read("t5_pending_idle", 2'd1, 16'h0000);

    // 6: W1C colliding with a new edge; CTRL bits; reset mid-ARM
    reg_write(2'd3, 16'h0000);
    reg_write(2'd0, 16'h0004);
    pulse(2);
    repeat (3) tick();
    reg_read("t6_pending_set", 2'd1, 16'h0004);
    tick();
    irq_src[2] = 1'b1;
    tick();
    tick();
    reg_wr    = 1'b1;
    reg_addr  = 2'd1;
    reg_wdata = 16'h0004;
    tick();
    reg_wr     = 1'b0;
    irq_src[2] = 1'b0;
    reg_read("t6_set_wins", 2'd1, 16'h0004);
    reg_write(2'd1, 16'h0004);
    reg_read("t6_w1c_clears", 2'd1, 16'h0000);
    reg_write(2'd3, 16'hFFFF);
    reg_read("t6_ctrl_bits", 2'd3, 16'h0001);
    p_cache_miss = 1'b1;
    pulse(2);
    repeat (6) tick();
    check("t6_arm_addr", 32'(int_addr), 2);
    check("t6_arm_int_pending", 32'(int_pending), 1);
    rst = 1'b1;
    #1;
    check("t6_rst_interrupt", 32'(interrupt), 0);
    check("t6_rst_int_addr", 32'(int_addr), 0);
    check("t6_rst_int_pending", 32'(int_pending), 0);
    check("t6_rst_rdata", 32'(reg_rdata), 0);
    tick();
    rst          = 1'b0;
    p_cache_miss = 1'b0;
    repeat (10) tick();
    reg_read("t6_pending_lost", 2'd1, 16'h0000);
    reg_read("t6_enable_reset", 2'd0, 16'h0000);
    reg_read("t6_ctrl_reset", 2'd3, 16'h0000);

    repeat (4) tick();
    check("leftover_int", 32'(int_q.size()), 0);
    check("leftover_rd", 32'(rd_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
